// File: rtl/ecc_sed_enc_arbiter_if.sv
// Bundle between the requesting clients, the shared parity encoder stage and
// the downstream ECC-protected consumer.
interface ecc_sed_enc_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 12,
  parameter int SW   = $clog2(NREQ)
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               out_valid;
  logic               out_ready;
  logic [DW:0]        out_codeword;
  logic [SW-1:0]      out_src;
  logic               clr_count;
  logic [15:0]        enc_count;

  modport master (
    output req_valid, req_data, out_ready, clr_count,
    input  req_ready, out_valid, out_codeword, out_src, enc_count
  );

  modport slave (
    input  req_valid, req_data, out_ready, clr_count,
    output req_ready, out_valid, out_codeword, out_src, enc_count
  );
endinterface

// File: rtl/ecc_sed_enc_arbiter.sv
// Round-robin arbiter sharing one even-parity encoder among NREQ requesters,
// with a single registered output stage and a saturating delivery counter.
module ecc_sed_enc_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 12,
  parameter int SW   = $clog2(NREQ)
) (
  input logic                 clk,
  input logic                 rst,
  ecc_sed_enc_arbiter_if.slave bus
);

  function automatic logic parity_f(input logic [DW-1:0] d);
    parity_f = ^d;
  endfunction

  logic [SW-1:0]   ptr_r;
  logic            out_valid_r;
  logic [DW:0]     out_codeword_r;
  logic [SW-1:0]   out_src_r;
  logic [15:0]     enc_count_r;

  logic            load_en_s;
  logic            found_s;
  logic            grant_s;
  logic            hs_s;
  logic [SW-1:0]   winner_s;
  logic [SW-1:0]   ptr_next_s;
  logic [DW-1:0]   win_data_s;
  logic [NREQ-1:0] req_ready_s;

  // Round-robin search: walk downward so the candidate nearest ptr is kept last
  always_comb begin
    logic [SW:0] idx_v;
    found_s  = 1'b0;
    winner_s = '0;
    idx_v    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx_v = {1'b0, ptr_r} + (SW+1)'(k);
      if (idx_v >= (SW+1)'(NREQ)) begin
        idx_v = idx_v - (SW+1)'(NREQ);
      end else begin
        idx_v = idx_v;
      end
      if (bus.req_valid[idx_v[SW-1:0]]) begin
        found_s  = 1'b1;
        winner_s = idx_v[SW-1:0];
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Grant qualification, handshake detection and next-pointer wrap
  always_comb begin
    load_en_s  = !out_valid_r || bus.out_ready;
    grant_s    = rst && load_en_s && found_s;
    hs_s       = out_valid_r && bus.out_ready;
    win_data_s = bus.req_data[int'(winner_s) * DW +: DW];
    if (winner_s == SW'(NREQ - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = winner_s + SW'(1);
    end
    for (int i = 0; i < NREQ; i++) begin
      req_ready_s[i] = grant_s && (winner_s == SW'(i));
    end
  end

  // Output stage and arbitration pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_r    <= 1'b0;
      out_codeword_r <= '0;
      out_src_r      <= '0;
      ptr_r          <= '0;
    end else if (grant_s) begin
      out_valid_r    <= 1'b1;
      out_codeword_r <= {parity_f(win_data_s), win_data_s};
      out_src_r      <= winner_s;
      ptr_r          <= ptr_next_s;
    end else if (bus.out_ready) begin
      out_valid_r    <= 1'b0;
    end else begin
      out_valid_r    <= out_valid_r;
    end
  end

  // Saturating delivered-codeword counter; clear beats a same-cycle handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enc_count_r <= 16'h0000;
    end else if (bus.clr_count) begin
      enc_count_r <= 16'h0000;
    end else if (hs_s && (enc_count_r != 16'hFFFF)) begin
      enc_count_r <= enc_count_r + 16'h0001;
    end else begin
      enc_count_r <= enc_count_r;
    end
  end

  assign bus.req_ready    = req_ready_s;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_codeword = out_codeword_r;
  assign bus.out_src      = out_src_r;
  assign bus.enc_count    = enc_count_r;

endmodule

// File: tb/tb_ecc_sed_enc_arbiter.sv
// Scoreboard bench: a behavioural arbiter model predicts grants and codewords,
// an independent monitor pops and checks them at each output handshake.
module tb_ecc_sed_enc_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 12;
  localparam int SW   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ecc_sed_enc_arbiter_if #(.NREQ(NREQ), .DW(DW), .SW(SW)) bus ();
  ecc_sed_enc_arbiter #(.NREQ(NREQ), .DW(DW), .SW(SW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  logic [DW:0]   sb_cw[$];
  logic [SW-1:0] sb_src[$];
  logic [DW:0]   lit_cw[$];
  logic [SW-1:0] lit_src[$];

  int m_ptr   = 0;
  bit m_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NREQ*DW-1:0] rnd_data();
    logic [NREQ*DW-1:0] d;
    for (int i = 0; i < NREQ; i++) d[i*DW +: DW] = DW'($urandom);
    return d;
  endfunction

  // Reference: a word is accepted when the output slot is free or draining;
  // the first valid requester at or after ptr (circularly) wins.
  task automatic model_check();
    logic [NREQ-1:0] exp_ready;
    logic [DW-1:0]   d;
    int              win;
    bit              load;
    exp_ready = '0;
    if (!rst) begin
      m_valid = 1'b0;
      m_ptr   = 0;
      sb_cw.delete(); sb_src.delete(); lit_cw.delete(); lit_src.delete();
      chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
      return;
    end
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    load = !m_valid || bus.out_ready;
    win  = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (win < 0 && bus.req_valid[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
    end
    if (load && win >= 0) begin
      exp_ready[win] = 1'b1;
      d = bus.req_data[win*DW +: DW];
      sb_cw.push_back({1'($countones(d) % 2), d});
      sb_src.push_back(SW'(win));
      m_ptr   = (win + 1) % NREQ;
      m_valid = 1'b1;
    end else if (bus.out_ready) begin
      m_valid = 1'b0;
    end
    chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
  endtask

  task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*DW-1:0] d,
                      input logic r, input logic c, input logic rs);
    @(negedge clk);
    bus.req_valid = v;
    bus.req_data  = d;
    bus.out_ready = r;
    bus.clr_count = c;
    rst           = rs;
    #1;
    model_check();
  endtask

  // Monitor: checks enc_count, hold stability and popped codewords
  initial begin
    logic [15:0]   mcount;
    logic [DW:0]   exp_cw;
    logic [DW:0]   prev_cw;
    logic [SW-1:0] prev_src;
    bit            prev_hold;
    mcount    = 16'h0000;
    prev_hold = 1'b0;
    prev_cw   = '0;
    prev_src  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        mcount    = 16'h0000;
        prev_hold = 1'b0;
        chk("reset_enc_count", 32'(bus.enc_count), 32'd0);
        chk("reset_out_src", 32'(bus.out_src), 32'd0);
      end else begin
        chk("enc_count", 32'(bus.enc_count), 32'(mcount));
        if (prev_hold) begin
          chk("hold_codeword", 32'(bus.out_codeword), 32'(prev_cw));
          chk("hold_src", 32'(bus.out_src), 32'(prev_src));
        end
        prev_hold = bus.out_valid && !bus.out_ready;
        prev_cw   = bus.out_codeword;
        prev_src  = bus.out_src;
        if (bus.out_valid && bus.out_ready) begin
          if (sb_cw.size() == 0) begin
            chk("unexpected_output", 32'd1, 32'd0);
          end else begin
            exp_cw = sb_cw.pop_front();
            chk("codeword", 32'(bus.out_codeword), 32'(exp_cw));
            chk("out_src", 32'(bus.out_src), 32'(sb_src.pop_front()));
          end
          if (lit_cw.size() != 0) chk("parity_literal", 32'(bus.out_codeword), 32'(lit_cw.pop_front()));
          if (lit_src.size() != 0) chk("order_literal", 32'(bus.out_src), 32'(lit_src.pop_front()));
        end
        if (bus.clr_count) mcount = 16'h0000;
        else if (bus.out_valid && bus.out_ready && mcount != 16'hFFFF) mcount = mcount + 16'h0001;
      end
    end
  end

  initial begin
    logic [NREQ*DW-1:0] d;
    logic [DW-1:0]      pdat[4];
    logic [DW:0]        pcw[4];
    bus.req_valid = '0; bus.req_data = '0; bus.out_ready = 1'b0; bus.clr_count = 1'b0;

    // Reset with random inputs, then idle
    for (int i = 0; i < 4; i++) step(NREQ'($urandom), rnd_data(), 1'($urandom), 1'($urandom), 1'b0);
    for (int i = 0; i < 10; i++) step('0, rnd_data(), 1'b1, 1'b0, 1'b1);

    // Parity encoding on requester 1
    pdat = '{12'h001, 12'h003, 12'hFFF, 12'h7FF};
    pcw  = '{13'h1001, 13'h0003, 13'h0FFF, 13'h17FF};
    for (int i = 0; i < 4; i++) begin lit_cw.push_back(pcw[i]); lit_src.push_back(SW'(1)); end
    for (int i = 0; i < 4; i++) begin
      d = rnd_data();
      d[DW +: DW] = pdat[i];
      step(4'b0010, d, 1'b1, 1'b0, 1'b1);
    end
    step('0, rnd_data(), 1'b1, 1'b0, 1'b1);
    step('0, rnd_data(), 1'b1, 1'b0, 1'b1);
    chk("parity_enc_count", 32'(bus.enc_count), 32'd4);

    // Round-robin fairness, all four then requester 2 dropped
    step('0, rnd_data(), 1'b1, 1'b0, 1'b0);
    step('0, rnd_data(), 1'b1, 1'b0, 1'b1);
    foreach (pdat[i]) lit_src.push_back(SW'(i));
    lit_src.push_back(SW'(0)); lit_src.push_back(SW'(1));
    for (int i = 0; i < 6; i++) step(4'b1111, rnd_data(), 1'b1, 1'b0, 1'b1);
    step('0, rnd_data(), 1'b1, 1'b0, 1'b1);
    step('0, rnd_data(), 1'b1, 1'b0, 1'b0);
    step('0, rnd_data(), 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin lit_src.push_back(SW'(0)); lit_src.push_back(SW'(1)); lit_src.push_back(SW'(3)); end
    for (int i = 0; i < 6; i++) step(4'b1011, rnd_data(), 1'b1, 1'b0, 1'b1);
    step('0, rnd_data(), 1'b1, 1'b0, 1'b1);

    // Backpressure: hold for 5 cycles then release
    step(4'b1111, rnd_data(), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(4'b1111, rnd_data(), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b1111, rnd_data(), 1'b1, 1'b0, 1'b1);
    step('0, rnd_data(), 1'b1, 1'b0, 1'b1);

    // Random traffic
    for (int i = 0; i < 1500; i++)
      step(NREQ'($urandom), rnd_data(), ($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0), 1'b1);
    step('0, rnd_data(), 1'b1, 1'b0, 1'b1);

    // Counter saturation then clear during a handshake
    for (int i = 0; i < 65540; i++) step(4'b0001, rnd_data(), 1'b1, 1'b0, 1'b1);
    chk("count_saturated", 32'(bus.enc_count), 32'hFFFF);
    step(4'b0001, rnd_data(), 1'b1, 1'b1, 1'b1);
    step(4'b0001, rnd_data(), 1'b1, 1'b0, 1'b1);
    chk("count_cleared", 32'(bus.enc_count), 32'd0);
    step('0, rnd_data(), 1'b1, 1'b0, 1'b1);
    step('0, rnd_data(), 1'b1, 1'b0, 1'b1);

    // Reset mid-operation with out_valid=1 and ptr=2
    step(4'b0010, rnd_data(), 1'b0, 1'b0, 1'b1);
    step(4'b1111, rnd_data(), 1'b0, 1'b0, 1'b1);
    step(4'b1111, rnd_data(), 1'b0, 1'b0, 1'b0);
    step(4'b1111, rnd_data(), 1'b1, 1'b0, 1'b1);
    lit_src.push_back(SW'(0));
    step(4'b1111, rnd_data(), 1'b1, 1'b0, 1'b1);
    step('0, rnd_data(), 1'b1, 1'b0, 1'b1);
    step('0, rnd_data(), 1'b1, 1'b0, 1'b1);
    step('0, rnd_data(), 1'b1, 1'b0, 1'b1);
    chk("scoreboard_drained", 32'(sb_cw.size()), 32'd0);
    chk("literals_drained", 32'(lit_src.size() + lit_cw.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
